// File: rtl/attn_pkg.sv
// Shared definitions for the attention-core instruction sequencer: bus field
// layout, mac mode encodings and the sequencer state type.
package attn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KLOAD,
      EXEC,
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] MAC_IDLE = 2'b00;
   localparam logic [1:0] MAC_LOAD = 2'b01;
   localparam logic [1:0] MAC_EXEC = 2'b10;

   localparam int PMEM_WR_BIT  = 0;
   localparam int PMEM_RD_BIT  = 1;
   localparam int KMEM_WR_BIT  = 2;
   localparam int KMEM_RD_BIT  = 3;
   localparam int QMEM_WR_BIT  = 4;
   localparam int QMEM_RD_BIT  = 5;
   localparam int MAC_LSB      = 6;
   localparam int PMEM_ADD_LSB = 8;

   function automatic int qkmem_add_lsb(input int aw);
      return PMEM_ADD_LSB + aw;
   endfunction

   function automatic int ofifo_rd_bit(input int aw);
      return PMEM_ADD_LSB + 2 * aw;
   endfunction

   function automatic int sfp_lsb(input int aw);
      return PMEM_ADD_LSB + 2 * aw + 1;
   endfunction

   function automatic int inst_w(input int aw);
      return 2 * aw + 11;
   endfunction

endpackage

// File: rtl/attn_delay_line.sv
// Fixed-latency shift register that turns each ofifo read into the matching
// pmem write DEPTH cycles later, carrying the write address alongside.
module attn_delay_line #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_add,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_add
);

   logic [DEPTH-1:0]             vld;
   logic [DEPTH-1:0][ADDR_W-1:0] add;

   // NOTE: this storage is a handful of flops, not a RAM, so clearing it on reset is cheap and keeps the bus quiet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld <= '0;
         add <= '0;
      end else if (clear) begin
         vld <= '0;
         add <= '0;
      end else begin
         vld[0] <= in_valid;
         add[0] <= in_valid ? in_add : '0;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            add[i] <= add[i-1];
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_add   = add[DEPTH-1];

endmodule

// File: rtl/attn_seq.sv
// Autonomous instruction sequencer: loads COL keys, streams q_len queries and
// drains the output FIFO through the SFP into pmem on one start pulse.
module attn_seq
   import attn_pkg::*;
#(
   parameter int COL     = 8,
   parameter int ADDR_W  = 4,
   parameter int SFP_LAT = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic [ADDR_W:0]             q_len,
   input  logic [ADDR_W-1:0]           k_base,
   input  logic [ADDR_W-1:0]           q_base,
   input  logic [ADDR_W-1:0]           p_base,
   input  logic [1:0]                  sfp_mode,
   input  logic                        fifo_valid,
   output logic [inst_w(ADDR_W)-1:0]   inst,
   output logic                        busy,
   output logic                        done
);

   localparam int QK_LSB    = qkmem_add_lsb(ADDR_W);
   localparam int OFIFO_BIT = ofifo_rd_bit(ADDR_W);
   localparam int SFP_LSB   = sfp_lsb(ADDR_W);
   localparam int IDX_W     = ($clog2(COL) > ADDR_W + 1) ? $clog2(COL) : ADDR_W + 1;

   localparam logic [ADDR_W:0]  Q_MAX    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COL - 1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [ADDR_W:0]   rd_cnt;
   logic [ADDR_W:0]   wr_cnt;
   logic [ADDR_W:0]   q_n;
   logic [ADDR_W-1:0] k_base_r;
   logic [ADDR_W-1:0] q_base_r;
   logic [ADDR_W-1:0] p_base_r;
   logic [1:0]        sfp_mode_r;
   logic              kmem_rd;
   logic              qmem_rd;
   logic [ADDR_W-1:0] qk_add;
   logic [1:0]        mac;
   logic              sfp_on;

   logic              ofifo_rd;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_add;
   logic              last_wr;
   logic [ADDR_W:0]   q_sat;

   assign q_sat    = (q_len > Q_MAX) ? Q_MAX : q_len;
   // A read is issued in the same cycle fifo_valid is seen, so the FIFO is never read empty.
   assign ofifo_rd = (state == DRAIN) && fifo_valid && (rd_cnt < q_n);
   assign last_wr  = wr_valid && (wr_cnt + 1'b1 == q_n);

   attn_delay_line #(
      .ADDR_W (ADDR_W),
      .DEPTH  (SFP_LAT)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .clear     (abort),
      .in_valid  (ofifo_rd),
      .in_add    (p_base_r + rd_cnt[ADDR_W-1:0]),
      .out_valid (wr_valid),
      .out_add   (wr_add)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         rd_cnt     <= '0;
         wr_cnt     <= '0;
         q_n        <= '0;
         k_base_r   <= '0;
         q_base_r   <= '0;
         p_base_r   <= '0;
         sfp_mode_r <= '0;
         kmem_rd    <= 1'b0;
         qmem_rd    <= 1'b0;
         qk_add     <= '0;
         mac        <= MAC_IDLE;
         sfp_on     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (abort) begin
         state   <= IDLE;
         idx     <= '0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         kmem_rd <= 1'b0;
         qmem_rd <= 1'b0;
         qk_add  <= '0;
         mac     <= MAC_IDLE;
         sfp_on  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         // Mac mode follows the SRAM read issued one cycle earlier.
         mac     <= qmem_rd ? MAC_EXEC : (kmem_rd ? MAC_LOAD : MAC_IDLE);
         done    <= 1'b0;
         kmem_rd <= 1'b0;
         qmem_rd <= 1'b0;
         qk_add  <= '0;
         if (ofifo_rd) begin
            rd_cnt <= rd_cnt + 1'b1;
            sfp_on <= 1'b1;
         end
         if (wr_valid) wr_cnt <= wr_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  k_base_r   <= k_base;
                  q_base_r   <= q_base;
                  p_base_r   <= p_base;
                  sfp_mode_r <= sfp_mode;
                  q_n        <= q_sat;
                  idx        <= '0;
                  rd_cnt     <= '0;
                  wr_cnt     <= '0;
                  busy       <= 1'b1;
                  // An empty run goes through DRAIN, which finishes at once with zero writes.
                  if (q_sat == '0) begin
                     state <= DRAIN;
                  end else begin
                     state   <= KLOAD;
                     kmem_rd <= 1'b1;
                     qk_add  <= k_base;
                  end
               end
            end
            KLOAD: begin
               if (idx == COL_LAST) begin
                  state   <= EXEC;
                  idx     <= '0;
                  qmem_rd <= 1'b1;
                  qk_add  <= q_base_r;
               end else begin
                  idx     <= idx + 1'b1;
                  kmem_rd <= 1'b1;
                  qk_add  <= k_base_r + ADDR_W'(idx + 1'b1);
               end
            end
            EXEC: begin
               if (idx == IDX_W'(q_n - 1'b1)) begin
                  state <= DRAIN;
                  idx   <= '0;
               end else begin
                  idx     <= idx + 1'b1;
                  qmem_rd <= 1'b1;
                  qk_add  <= q_base_r + ADDR_W'(idx + 1'b1);
               end
            end
            DRAIN: begin
               if (wr_cnt == q_n || last_wr) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  sfp_on <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      inst                           = '0;
      inst[PMEM_WR_BIT]              = wr_valid;
      inst[PMEM_RD_BIT]              = 1'b0;
      inst[KMEM_WR_BIT]              = 1'b0;
      inst[KMEM_RD_BIT]              = kmem_rd;
      inst[QMEM_WR_BIT]              = 1'b0;
      inst[QMEM_RD_BIT]              = qmem_rd;
      inst[MAC_LSB +: 2]             = mac;
      inst[PMEM_ADD_LSB +: ADDR_W]   = wr_add;
      inst[QK_LSB +: ADDR_W]         = qk_add;
      inst[OFIFO_BIT]                = ofifo_rd;
      inst[SFP_LSB +: 2]             = (sfp_on || ofifo_rd) ? sfp_mode_r : 2'b00;
   end

endmodule

// File: tb/tb_attn_seq.sv
// Randomised scoreboard bench for attn_seq: two instances (SFP_LAT 1 and 3)
// share stimulus; a cycle-indexed reference model predicts every busy cycle.
module tb_attn_seq;

   localparam int COL  = 8;
   localparam int AW   = 4;
   localparam int IW   = 2 * AW + 11;
   localparam int MAXC = 256;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          fifo_valid = 1'b0;
   logic [AW:0]   q_len = '0;
   logic [AW-1:0] k_base = '0;
   logic [AW-1:0] q_base = '0;
   logic [AW-1:0] p_base = '0;
   logic [1:0]    sfp_mode = '0;

   logic [IW-1:0] inst1, inst3;
   logic          busy1, busy3, done1, done3;

   int            cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [63:0]   q1[$];
   logic [63:0]   q3[$];
   bit            fv[MAXC];

   attn_seq #(.COL(COL), .ADDR_W(AW), .SFP_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .q_len(q_len),
      .k_base(k_base), .q_base(q_base), .p_base(p_base), .sfp_mode(sfp_mode),
      .fifo_valid(fifo_valid), .inst(inst1), .busy(busy1), .done(done1)
   );

   attn_seq #(.COL(COL), .ADDR_W(AW), .SFP_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .q_len(q_len),
      .k_base(k_base), .q_base(q_base), .p_base(p_base), .sfp_mode(sfp_mode),
      .fifo_valid(fifo_valid), .inst(inst3), .busy(busy3), .done(done3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack(input int c, input logic [IW-1:0] i, input logic b, input logic d);
      return {c, 11'd0, i, b, d};
   endfunction

   // Expected bus value for every cycle of one run, built from the schedule rules.
   task automatic model(input int lat, input int nraw, input int kb, input int qb, input int pb,
                        input int mode, input int last, input int s0, output int d);
      int n, rd, first, lastrd;
      int ins[MAXC];
      logic [63:0] e;
      n = (nraw > 16) ? 16 : nraw;
      foreach (ins[c]) ins[c] = 0;
      if (n == 0) begin
         d = 2;
      end else begin
         for (int i = 0; i < COL; i++) begin
            ins[1+i] |= (1 << 3) | (((kb + i) % 16) << 12);
            ins[2+i] |= 1 << 6;
         end
         for (int j = 0; j < n; j++) begin
            ins[COL+1+j] |= (1 << 5) | (((qb + j) % 16) << 12);
            ins[COL+2+j] |= 2 << 6;
         end
         rd = 0; first = 0; lastrd = 0;
         for (int c = COL + n + 1; rd < n && c < MAXC - 8; c++) begin
            if (fv[c]) begin
               ins[c] |= 1 << 16;
               ins[c+lat] |= 1 | (((pb + rd) % 16) << 8);
               if (rd == 0) first = c;
               lastrd = c;
               rd++;
            end
         end
         for (int c = first; c <= lastrd + lat; c++) ins[c] |= mode << 17;
         d = lastrd + lat + 1;
      end
      for (int c = 1; c <= d && c <= last; c++) begin
         e = pack(s0 + c - 1, IW'(ins[c]), 1'b1, c == d);
         if (lat == 1) q1.push_back(e);
         else q3.push_back(e);
      end
   endtask

   task automatic observe(input int lat, input logic [IW-1:0] i, input logic b, input logic d);
      logic [63:0] act;
      act = pack(cyc, i, b, d);
      if (lat == 1) begin
         if (q1.size() == 0) check("lat1_extra_output", act, 64'd0);
         else check("lat1_cycle", act, q1.pop_front());
      end else begin
         if (q3.size() == 0) check("lat3_extra_output", act, 64'd0);
         else check("lat3_cycle", act, q3.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (inst1 != '0 || busy1 || done1) observe(1, inst1, busy1, done1);
         if (inst3 != '0 || busy3 || done3) observe(3, inst3, busy3, done3);
      end
   end

   // stop_kind: 0 none, 1 abort in cycle 'at', 2 async reset in cycle 'at'.
   task automatic run(input int nraw, input int kb, input int qb, input int pb, input int mode,
                      input int fvk, input int stop_kind, input int at, input int spur);
      int s0, d1, d3, dmax, last;
      for (int c = 0; c < MAXC; c++) begin
         case (fvk)
            0:       fv[c] = 1'b1;
            1:       fv[c] = (c % 3 == 0);
            default: fv[c] = ($urandom_range(0, 1) == 1);
         endcase
         if (c >= 100) fv[c] = 1'b1;
      end
      q_len      = (AW+1)'(nraw);
      k_base     = AW'(kb);
      q_base     = AW'(qb);
      p_base     = AW'(pb);
      sfp_mode   = 2'(mode);
      fifo_valid = 1'b0;
      start      = 1'b1;
      @(posedge clk);
      #1;
      s0       = cyc;
      start    = 1'b0;
      q_len    = (AW+1)'($urandom);
      k_base   = AW'($urandom);
      q_base   = AW'($urandom);
      p_base   = AW'($urandom);
      sfp_mode = 2'($urandom);
      last = (stop_kind == 1) ? at : (stop_kind == 2) ? at - 1 : MAXC;
      model(1, nraw, kb, qb, pb, mode, last, s0, d1);
      model(3, nraw, kb, qb, pb, mode, last, s0, d3);
      dmax = (stop_kind != 0) ? at + 2 : ((d3 > d1) ? d3 : d1);
      for (int k = 1; k <= dmax + 2; k++) begin
         fifo_valid = fv[k];
         start      = (k == spur);
         abort      = (stop_kind == 1 && k == at);
         if (stop_kind == 2 && k == at) begin
            reset = 1'b1;
            #1;
            check("reset_inst1", 64'(inst1), 64'd0);
            check("reset_busy1", 64'(busy1), 64'd0);
            check("reset_inst3", 64'(inst3), 64'd0);
            check("reset_busy3", 64'(busy3), 64'd0);
         end
         @(posedge clk);
         #1;
         reset = 1'b0;
         abort = 1'b0;
      end
      start      = 1'b0;
      fifo_valid = 1'b0;
      check("lat1_pending", 64'(q1.size()), 64'd0);
      check("lat3_pending", 64'(q3.size()), 64'd0);
      q1.delete();
      q3.delete();
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_inst1", 64'(inst1), 64'd0);
      check("rst_busy1", 64'(busy1), 64'd0);
      check("rst_done1", 64'(done1), 64'd0);
      check("rst_inst3", 64'(inst3), 64'd0);
      check("rst_done3", 64'(done3), 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run(8, 0, 0, 0, 3, 0, 0, 0, 3);
      run(4, 14, 15, 13, 2, 0, 0, 0, 3);
      run(6, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, 0, 0, 3);
      run(0, 5, 6, 7, 3, 0, 0, 0, 2);
      run(31, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 2, 2, 0, 0, 3);
      run(8, 3, 4, 5, 1, 0, 1, COL + 8 + 2, 3);
      run(8, 1, 2, 3, 3, 0, 2, COL + 3, 3);
      run(5, 9, 10, 11, 2, 0, 0, 0, 3);
      for (int r = 0; r < 10; r++) begin
         run($urandom_range(0, 20), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 3), 2, 0, 0, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
